// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: delays pixels 11 cycles and inserts preamble/guard.
// Ports: clk/resetn, dvi_mode, in_* video, enc_* to TMDS encoders, guard_*, status.
module hdmi_period_scheduler #(
  parameter int MIN_BLANK = 12
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       dvi_mode,
  input  logic       in_de,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic       enc_de,
  output logic [7:0] enc_d0,
  output logic [7:0] enc_d1,
  output logic [7:0] enc_d2,
  output logic [1:0] enc_c0,
  output logic [1:0] enc_c1,
  output logic [1:0] enc_c2,
  output logic       guard_sel,
  output logic [9:0] guard_word0,
  output logic [9:0] guard_word1,
  output logic [9:0] guard_word2,
  output logic [1:0] sched_state,
  output logic       short_blank_err
);

  typedef enum logic [1:0] {
    CTRL  = 2'd0,
    PRE   = 2'd1,
    GUARD = 2'd2,
    VIDEO = 2'd3
  } state_t;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } px_t;

  localparam logic [9:0] GW_B = 10'b1011001100;
  localparam logic [9:0] GW_G = 10'b0100110011;

  px_t    in_px;
  px_t    pipe [10];
  px_t    dly;
  logic   in_de_q;
  logic [7:0] blank_cnt;
  state_t state, state_nxt;
  logic [2:0] phase, phase_nxt;
  logic   rise, long_ok, err_set, vid_nxt;

  assign in_px = {in_de, in_hsync, in_vsync, in_r, in_g, in_b};
  assign dly   = pipe[9];
  assign rise  = in_de & ~in_de_q;
  assign long_ok = int'(blank_cnt) >= MIN_BLANK;
  assign vid_nxt = state_nxt == VIDEO;
  assign sched_state = state;
  assign enc_c2 = 2'b00;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 10; i++) pipe[i] <= '0;
      in_de_q   <= 1'b0;
      blank_cnt <= '0;
    end else begin
      pipe[0] <= in_px;
      for (int i = 1; i < 10; i++) pipe[i] <= pipe[i-1];
      in_de_q <= in_de;
      if (in_de)
        blank_cnt <= '0;
      else if (blank_cnt != 8'hff)
        blank_cnt <= blank_cnt + 8'd1;
    end
  end

  // The state tracks the cycle currently on enc_*; it moves on the same
  // edge that loads the output registers from the last delay stage.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    err_set   = 1'b0;
    unique case (state)
      CTRL: begin
        if (dly.de) state_nxt = VIDEO;
      end
      PRE: begin
        phase_nxt = phase + 3'd1;
        if (phase == 3'd7) begin
          state_nxt = GUARD;
          phase_nxt = '0;
        end
      end
      GUARD: begin
        phase_nxt = phase + 3'd1;
        if (phase == 3'd1) begin
          state_nxt = dly.de ? VIDEO : CTRL;
          phase_nxt = '0;
        end
      end
      VIDEO: begin
        if (!dly.de) state_nxt = CTRL;
      end
    endcase
    // A rise is 11 cycles ahead of the output, leaving room for 8+2
    // inserted cycles only if the previous run has drained.
    if (rise && !dvi_mode) begin
      if (long_ok && !dly.de &&
          (state == CTRL || state == VIDEO)) begin
        state_nxt = PRE;
        phase_nxt = '0;
      end else begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= CTRL;
      phase           <= '0;
      enc_de          <= 1'b0;
      enc_d0          <= '0;
      enc_d1          <= '0;
      enc_d2          <= '0;
      enc_c0          <= '0;
      enc_c1          <= '0;
      guard_sel       <= 1'b0;
      guard_word0     <= '0;
      guard_word1     <= '0;
      guard_word2     <= '0;
      short_blank_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      enc_de <= vid_nxt;
      enc_d0 <= vid_nxt ? dly.b : 8'd0;
      enc_d1 <= vid_nxt ? dly.g : 8'd0;
      enc_d2 <= vid_nxt ? dly.r : 8'd0;
      enc_c0 <= {dly.vs, dly.hs};
      enc_c1 <= (state_nxt == PRE) ? 2'b01 : 2'b00;
      // Guard symbols lag one cycle to line up with encoder latency.
      guard_sel   <= state == GUARD;
      guard_word0 <= (state == GUARD) ? GW_B : 10'd0;
      guard_word1 <= (state == GUARD) ? GW_G : 10'd0;
      guard_word2 <= (state == GUARD) ? GW_B : 10'd0;
      short_blank_err <= short_blank_err | err_set;
    end
  end

endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Sits between the video timing/pattern generator and the three per-channel TMDS encoders.
- Delays the pixel stream by a fixed pipeline so it can insert the HDMI video preamble (8 cycles) and the leading guard band (2 cycles) into the tail of each blanking interval.
- Drives each encoder's DE/D/C1/C0, plus a guard-band override word that the serializer mux substitutes for encoder output.
- Falls back to plain DVI sequencing (no preamble/guard) on request or when blanking is too short.

Parameters:
- MIN_BLANK, 12: minimum input blanking run, in cycles, required before preamble insertion. Legal range ≥ 10.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- dvi_mode  in  1  1 = never insert preamble/guard. Sampled only at input DE rising edge.
- in_de  in  1  active video from timing generator.
- in_hsync  in  1  hsync.
- in_vsync  in  1  vsync.
- in_r, in_g, in_b  in  8 each  pixel data.
- enc_de  out  1  DE to all three encoders.
- enc_d0 / enc_d1 / enc_d2  out  8 each  pixel data to encoder channels: ch0 = blue, ch1 = green, ch2 = red.
- enc_c0  out  2  ch0 {C1,C0} = {vsync,hsync}.
- enc_c1  out  2  ch1 {C1,C0} = {CTL1,CTL0}.
- enc_c2  out  2  ch2 {C1,C0} = {CTL3,CTL2}.
- guard_sel  out  1  1 = serializer uses guard_wordN instead of encoder output (aligned to the encoder's 1-cycle latency).
- guard_word0 / guard_word1 / guard_word2  out  10 each  guard-band symbols.
- sched_state  out  2  0 CTRL, 1 PREAMBLE, 2 GUARD, 3 VIDEO.
- short_blank_err  out  1  sticky; set when a preamble had to be skipped.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state CTRL; delay line cleared (blanking, syncs low); blank counter 0; short_blank_err 0.
- Delay line: 10 stages of {de,hsync,vsync,r,g,b}. Outputs are registered.
- Total latency: in_* at cycle n appears on enc_* at n+11.
- guard_sel is registered one cycle later than enc_* (n+12), matching encoder latency.
- Blank counter: counts consecutive cycles of in_de=0, saturating at 255; cleared while in_de=1.
- Rise detect: rise = in_de & ~in_de_q.
- State machine (single phase counter, 0..7):
  - CTRL: enc_de=0; ch0 syncs from the delay line; CTL0..3 = 0.
    - If rise & ~dvi_mode & blank_cnt ≥ MIN_BLANK → PREAMBLE, counter=0.
    - If rise & ~dvi_mode & blank_cnt < MIN_BLANK → VIDEO when delayed DE rises; set short_blank_err.
    - If rise & dvi_mode → VIDEO when delayed DE rises; no error.
  - PREAMBLE, 8 cycles: enc_de=0; CTL0=1, CTL1=CTL2=CTL3=0; ch0 syncs still follow the delay line. After the 8th cycle → GUARD.
  - GUARD, 2 cycles: enc_de=0; guard_sel=1.
    - guard_word0 = 10'b1011001100, guard_word1 = 10'b0100110011, guard_word2 = 10'b1011001100.
    - After the 2nd cycle the delayed DE is 1 → VIDEO.
  - VIDEO: enc_de=1; enc_dN = delayed pixel. When delayed DE falls → CTRL on that cycle (trailing edge needs no guard).
- Alignment: the first VIDEO output cycle is exactly the cycle after the last GUARD cycle, with no gap and no overlap.
- Active run length is preserved exactly. A 1-pixel active run is legal.
- A rise cannot occur while in PREAMBLE or GUARD, because MIN_BLANK ≥ 10. If it does (illegal parameter), ignore it and set short_blank_err.
- guard_word* = 0 whenever guard_sel = 0.
- dvi_mode changes mid-line have no effect until the next rise.
- Reset asserted mid-line: outputs drop to 0 immediately. After release, the first line is treated as short blank (counter 0), so no preamble is inserted and short_blank_err is set if ~dvi_mode.

Test Plan:
- 800-pixel line, 160 blanking cycles, dvi_mode=0 → enc_de=0 for 150 cycles, then PREAMBLE 8 cycles with enc_c1=2'b01 and enc_c2=2'b00, then GUARD 2 cycles (guard_sel=1, words 0x2CC/0x133/0x2CC), then enc_de=1 for exactly 800 cycles; pixel k input at n appears at n+11.
- Same timing with dvi_mode=1 → no PREAMBLE/GUARD; enc_c1=enc_c2=0 throughout; enc_de pattern equal to in_de delayed 11.
- Blanking of 11 cycles with MIN_BLANK=12 → no preamble; video passes delayed; short_blank_err=1 and stays 1 over subsequent good lines.
- hsync toggling during PREAMBLE → enc_c0 reproduces hsync/vsync delayed 11 with no glitch; CTL values unaffected.
- 1-pixel active run after 20-cycle blank → PREAMBLE 8, GUARD 2, VIDEO 1, CTRL; blank counter restarts.
- resetn pulled low during VIDEO at pixel 400 → all outputs 0 asynchronously. After release, the next line gets no preamble and short_blank_err=1; the line after gets a full preamble.
